// File: rtl/iob_vexriscv_bus_arbiter.sv
// Two-master IOb arbiter: shares one memory port between the VexRiscv
// instruction bus (I, read-only) and data bus (D). One transaction in flight.
//
// state  | meaning
// IDLE   | no transaction; grant the next request (I and/or D valid)
// REQ    | m_valid high, waiting for memory to accept (m_ready)
// WAIT_R | read accepted, waiting for m_rvalid to route back to owner

module iob_vexriscv_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int D_PRIO = 0
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                i_valid,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_ready,
   output logic                i_rvalid,
   output logic [DATA_W-1:0]   i_rdata,

   input  logic                d_valid,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_ready,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,

   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic                m_ready,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2
   } state_t;

   state_t              state, state_nxt;
   // owner / rr_last encoding: 0 = I bus, 1 = D bus
   logic                owner, owner_nxt;
   logic                rr_last, rr_last_nxt;
   logic                grant_d;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [DATA_W-1:0]   wdata_nxt;
   logic [STRB_W-1:0]   wstrb_nxt;

   // Read data is shared; only the rvalid strobes qualify it.
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;
   assign m_valid = (state == REQ);

   // State, ownership and latched memory request registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         owner   <= 1'b0;
         rr_last <= 1'b1;
         m_addr  <= '0;
         m_wdata <= '0;
         m_wstrb <= '0;
      end else begin
         state   <= state_nxt;
         owner   <= owner_nxt;
         rr_last <= rr_last_nxt;
         m_addr  <= addr_nxt;
         m_wdata <= wdata_nxt;
         m_wstrb <= wstrb_nxt;
      end
   end

   // Arbitration, next-state and owner-routed handshakes
   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      rr_last_nxt = rr_last;
      addr_nxt    = m_addr;
      wdata_nxt   = m_wdata;
      wstrb_nxt   = m_wstrb;
      i_ready     = 1'b0;
      d_ready     = 1'b0;
      i_rvalid    = 1'b0;
      d_rvalid    = 1'b0;

      // On contention round-robin picks the side that did not win last time.
      if (i_valid && d_valid) begin
         grant_d = (D_PRIO != 0) ? 1'b1 : ~rr_last;
      end else begin
         grant_d = d_valid;
      end

      case (state)
         IDLE: begin
            if (i_valid || d_valid) begin
               state_nxt   = REQ;
               owner_nxt   = grant_d;
               rr_last_nxt = grant_d;
               addr_nxt    = grant_d ? d_addr  : i_addr;
               wdata_nxt   = grant_d ? d_wdata : '0;
               wstrb_nxt   = grant_d ? d_wstrb : '0;
            end
         end
         REQ: begin
            i_ready = m_ready && !owner;
            d_ready = m_ready &&  owner;
            if (m_ready) begin
               state_nxt = (m_wstrb != '0) ? IDLE : WAIT_R;
            end
         end
         WAIT_R: begin
            i_rvalid = m_rvalid && !owner;
            d_rvalid = m_rvalid &&  owner;
            if (m_rvalid) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_iob_vexriscv_bus_arbiter.sv
// Self-checking bench for iob_vexriscv_bus_arbiter. Two instances (round-robin
// and D-priority) share stimulus; sel picks which one is observed.

module tb_iob_vexriscv_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        i_valid, d_valid, m_ready, m_rvalid;
   logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
   logic [3:0]  d_wstrb;

   logic        i_ready_x [2], i_rvalid_x [2], d_ready_x [2], d_rvalid_x [2], m_valid_x [2];
   logic [31:0] i_rdata_x [2], d_rdata_x [2], m_addr_x [2], m_wdata_x [2];
   logic [3:0]  m_wstrb_x [2];

   logic        i_ready, i_rvalid, d_ready, d_rvalid, m_valid;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic [3:0]  m_wstrb;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        owner;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   typedef struct {
      logic        owner;
      logic [31:0] rdata;
   } rsp_t;

   req_t req_q [$];
   rsp_t rsp_q [$];

   always #5 clk = ~clk;

   iob_vexriscv_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .D_PRIO(0)) dut_rr (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready_x[0]),
      .i_rvalid(i_rvalid_x[0]), .i_rdata(i_rdata_x[0]),
      .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_ready(d_ready_x[0]), .d_rvalid(d_rvalid_x[0]), .d_rdata(d_rdata_x[0]),
      .m_valid(m_valid_x[0]), .m_addr(m_addr_x[0]), .m_wdata(m_wdata_x[0]),
      .m_wstrb(m_wstrb_x[0]), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   iob_vexriscv_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .D_PRIO(1)) dut_dp (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready_x[1]),
      .i_rvalid(i_rvalid_x[1]), .i_rdata(i_rdata_x[1]),
      .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_ready(d_ready_x[1]), .d_rvalid(d_rvalid_x[1]), .d_rdata(d_rdata_x[1]),
      .m_valid(m_valid_x[1]), .m_addr(m_addr_x[1]), .m_wdata(m_wdata_x[1]),
      .m_wstrb(m_wstrb_x[1]), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
   );

   assign i_ready  = i_ready_x[sel];
   assign i_rvalid = i_rvalid_x[sel];
   assign i_rdata  = i_rdata_x[sel];
   assign d_ready  = d_ready_x[sel];
   assign d_rvalid = d_rvalid_x[sel];
   assign d_rdata  = d_rdata_x[sel];
   assign m_valid  = m_valid_x[sel];
   assign m_addr   = m_addr_x[sel];
   assign m_wdata  = m_wdata_x[sel];
   assign m_wstrb  = m_wstrb_x[sel];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic push_req(input logic owner, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
      req_t e;
      e.owner = owner;
      e.addr  = addr;
      e.wdata = wdata;
      e.wstrb = wstrb;
      req_q.push_back(e);
   endtask

   task automatic do_reset;
      rst      = 1'b1;
      i_valid  = 1'b0;
      d_valid  = 1'b0;
      m_ready  = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = 32'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      req_q.delete();
      rsp_q.delete();
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_addr",  m_addr, 0);
      check("rst_m_wstrb", m_wstrb, 0);
      check("rst_ready",   {i_ready, d_ready}, 0);
      check("rst_rvalid",  {i_rvalid, d_rvalid}, 0);
   endtask

   // Memory-side model: wait for a request, stall, accept, and for reads
   // answer rlat cycles after accept. Called and returns on a negedge.
   task automatic mem_serve(input int stall, input int rlat, input logic [31:0] rdata);
      req_t e;
      rsp_t r;
      int   n;
      n = 0;
      while (!m_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!m_valid) begin
         check("grant_timeout", m_valid, 1);
         return;
      end
      if (req_q.size() == 0) begin
         check("unexpected_req", m_valid, 0);
         return;
      end
      e = req_q.pop_front();
      for (int s = 0; s <= stall; s++) begin
         if (s == stall) m_ready = 1'b1;
         #1;
         check("m_valid", m_valid, 1);
         check("m_addr",  m_addr,  e.addr);
         check("m_wdata", m_wdata, e.wdata);
         check("m_wstrb", m_wstrb, e.wstrb);
         check("i_ready", i_ready, (s == stall) && !e.owner);
         check("d_ready", d_ready, (s == stall) &&  e.owner);
         @(negedge clk);
      end
      m_ready = 1'b0;
      #1;
      check("m_valid_after_accept", m_valid, 0);
      check("ready_pulse", {i_ready, d_ready}, 0);
      if (e.wstrb == 4'h0) begin
         r.owner = e.owner;
         r.rdata = rdata;
         rsp_q.push_back(r);
         for (int c = 1; c < rlat; c++) begin
            check("early_rvalid", {i_rvalid, d_rvalid}, 0);
            @(negedge clk);
            #1;
         end
         m_rvalid = 1'b1;
         m_rdata  = rdata;
         #1;
         r = rsp_q.pop_front();
         check("i_rvalid", i_rvalid, !r.owner);
         check("d_rvalid", d_rvalid,  r.owner);
         check("rdata", r.owner ? d_rdata : i_rdata, r.rdata);
         @(negedge clk);
         m_rvalid = 1'b0;
      end else begin
         check("write_rvalid", {i_rvalid, d_rvalid}, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic rr_model;
      logic w;
      sel     = 1'b0;
      i_addr  = 32'h0;
      d_addr  = 32'h0;
      d_wdata = 32'h0;
      d_wstrb = 4'h0;
      @(negedge clk);
      do_reset();

      // I read alone with one-cycle grant latency
      i_valid = 1'b1;
      i_addr  = 32'h100;
      push_req(1'b0, 32'h100, 32'h0, 4'h0);
      #1;
      check("grant_latency_pre", m_valid, 0);
      @(negedge clk);
      #1;
      check("grant_latency", m_valid, 1);
      mem_serve(0, 2, 32'hDEADBEEF);
      i_valid = 1'b0;

      // D write with three stall cycles
      @(negedge clk);
      d_valid = 1'b1;
      d_addr  = 32'h2004;
      d_wdata = 32'h12345678;
      d_wstrb = 4'hF;
      push_req(1'b1, 32'h2004, 32'h12345678, 4'hF);
      mem_serve(3, 1, 32'h0);
      d_valid = 1'b0;
      @(negedge clk);
      #1;
      check("write_idle", m_valid, 0);

      // Round-robin under continuous contention; rr_last resets to D so I wins first
      do_reset();
      rr_model = 1'b1;
      i_valid = 1'b1;
      i_addr  = 32'h1000;
      d_valid = 1'b1;
      d_addr  = 32'h3000;
      d_wdata = 32'h5500_0000;
      d_wstrb = 4'hF;
      for (int k = 0; k < 8; k++) begin
         w = ~rr_model;
         rr_model = w;
         push_req(w, w ? d_addr : i_addr, w ? d_wdata : 32'h0, w ? 4'hF : 4'h0);
         mem_serve(k % 2, 1 + (k % 3), 32'hA000_0000 + k);
         if (w) begin
            d_addr  = d_addr + 4;
            d_wdata = d_wdata + 1;
         end else begin
            i_addr = i_addr + 4;
         end
      end
      i_valid = 1'b0;
      d_valid = 1'b0;

      // D priority: D wins every contention, I only after d_valid drops
      sel = 1'b1;
      do_reset();
      i_valid = 1'b1;
      i_addr  = 32'h4000;
      d_valid = 1'b1;
      d_addr  = 32'h5000;
      d_wdata = 32'h0;
      d_wstrb = 4'h3;
      for (int k = 0; k < 4; k++) begin
         push_req(1'b1, d_addr, d_wdata, 4'h3);
         mem_serve(0, 1, 32'h0);
         d_addr  = d_addr + 4;
         d_wdata = d_wdata + 32'h11;
      end
      d_valid = 1'b0;
      push_req(1'b0, 32'h4000, 32'h0, 4'h0);
      mem_serve(0, 1, 32'hCAFE_F00D);
      i_valid = 1'b0;

      // Spurious m_rvalid in IDLE and in REQ
      sel = 1'b0;
      do_reset();
      m_rvalid = 1'b1;
      #1;
      check("spurious_idle_rvalid", {i_rvalid, d_rvalid}, 0);
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      check("spurious_idle_state", m_valid, 0);
      i_valid = 1'b1;
      i_addr  = 32'h600;
      @(negedge clk);
      m_rvalid = 1'b1;
      #1;
      check("spurious_req_rvalid", {i_rvalid, d_rvalid}, 0);
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      check("spurious_req_state", m_valid, 1);
      push_req(1'b0, 32'h600, 32'h0, 4'h0);
      mem_serve(0, 1, 32'h0BAD_CAFE);
      i_valid = 1'b0;

      // Reset during WAIT_R of a D read, late m_rvalid ignored
      @(negedge clk);
      d_valid = 1'b1;
      d_addr  = 32'h7000;
      d_wstrb = 4'h0;
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      check("abort_d_ready", d_ready, 1);
      @(negedge clk);
      m_ready = 1'b0;
      d_valid = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_m_valid", m_valid, 0);
      m_rvalid = 1'b1;
      m_rdata  = 32'h1111_2222;
      #1;
      check("abort_late_rvalid", {i_rvalid, d_rvalid}, 0);
      @(negedge clk);
      m_rvalid = 1'b0;
      i_valid  = 1'b1;
      i_addr   = 32'h800;
      push_req(1'b0, 32'h800, 32'h0, 4'h0);
      mem_serve(1, 2, 32'h3333_4444);
      i_valid = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
